// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: FSM state type, prescaler ratio and saturating arithmetic
// shared by the frequency meter blocks.
package freq_meter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      GATE = 2'd2
   } state_e;

   localparam int unsigned DIV_RATIO = 32'd10;
   localparam int          SAT_W     = 32'd64;

   typedef struct packed {
      logic             ovf;
      logic [SAT_W-1:0] val;
   } sat_t;

   // Clamp v into a w-bit unsigned range and flag when clamping happened.
   function automatic sat_t sat_clip(input logic [SAT_W-1:0] v, input int w);
      sat_t             r;
      logic [SAT_W-1:0] max_v;
      max_v = {SAT_W{1'b1}} >> (SAT_W - w);
      if (v > max_v) begin
         r.ovf = 1'b1;
         r.val = max_v;
      end else begin
         r.ovf = 1'b0;
         r.val = v;
      end
      return r;
   endfunction

   function automatic sat_t sat_add(input logic [SAT_W-1:0] a,
                                    input logic [SAT_W-1:0] b,
                                    input int               w);
      return sat_clip(a + b, w);
   endfunction

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer plus rising-edge detector for an
// asynchronous input; edge_pulse is high for one clk per detected rise.
module sync_edge_det #(
   parameter int SYNC_STAGES = 32'd2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic edge_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   hist_q;
   logic                   hist_d;

   // Next-state of the synchronizer chain and history flop.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
      hist_d = sync_q[SYNC_STAGES-1];
   end

   // Synchronizer and history registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{1'b0}};
         hist_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign edge_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts sig_in rising edges over back-to-back GATE_CYCLES windows.
// Optional autorange of the /10 prescaler: define FREQ_METER_AUTORANGE_EN.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int               GATE_CYCLES = 32'd1_000_000,
   parameter int               CNT_W       = 32'd24,
   parameter int               SYNC_STAGES = 32'd2,
   parameter logic [CNT_W-1:0] HI_TH       = 24'd900_000,
   parameter logic [CNT_W-1:0] LO_TH       = 24'd80_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq,
   output logic             freq_valid,
   output logic             overflow,
   output logic             busy,
   output logic             range_sel
);

   localparam int             GW   = (GATE_CYCLES > 32'd1) ? $clog2(GATE_CYCLES) : 32'd1;
   localparam logic [GW-1:0]  LAST = GW'(GATE_CYCLES - 32'd1);

   if (GATE_CYCLES < 32'd4) begin : g_gate_chk
      $error("freq_meter: GATE_CYCLES must be at least 4");
   end
   if (SYNC_STAGES < 32'd2) begin : g_sync_chk
      $error("freq_meter: SYNC_STAGES must be at least 2");
   end
   if (CNT_W >= SAT_W) begin : g_width_chk
      $error("freq_meter: CNT_W too wide for saturating helpers");
   end
   if (LO_TH >= HI_TH) begin : g_th_chk
      $error("freq_meter: LO_TH must be below HI_TH");
   end

   logic             edge_s;
   sat_t             add_s;
   logic [CNT_W-1:0] raw_s;
   logic             carry_s;
   logic             win_ovf_s;
   logic             last_s;

   state_e           state_q,    state_d;
   logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic             sat_q,      sat_d;
   logic [CNT_W-1:0] freq_q,     freq_d;
   logic             valid_q,    valid_d;
   logic             ovf_q,      ovf_d;
   logic             busy_q,     busy_d;

`ifdef FREQ_METER_AUTORANGE_EN
   sat_t             mul_s;
   logic             scaled_ovf_s;
   logic             range_q,    range_d;
   logic             discard_q,  discard_d;
`endif

   sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk        (clk),
      .rst        (rst),
      .d          (sig_in),
      .edge_pulse (edge_s)
   );

   // Window count including this cycle's edge; upper bits are always zero after clamping.
   always_comb begin
      add_s     = sat_add(SAT_W'(edge_cnt_q), SAT_W'(edge_s), CNT_W);
      raw_s     = add_s.val[CNT_W-1:0];
      carry_s   = add_s.ovf | (|add_s.val[SAT_W-1:CNT_W]);
      win_ovf_s = sat_q | carry_s;
      last_s    = (gate_cnt_q == LAST);
`ifdef FREQ_METER_AUTORANGE_EN
      mul_s        = sat_clip(SAT_W'(raw_s) * SAT_W'(DIV_RATIO), CNT_W);
      scaled_ovf_s = mul_s.ovf | (|mul_s.val[SAT_W-1:CNT_W]);
`endif
   end

   // Measurement FSM next-state and result computation.
   always_comb begin
      state_d    = state_q;
      gate_cnt_d = gate_cnt_q;
      edge_cnt_d = edge_cnt_q;
      sat_d      = sat_q;
      freq_d     = freq_q;
      ovf_d      = ovf_q;
      valid_d    = 1'b0;
`ifdef FREQ_METER_AUTORANGE_EN
      range_d    = range_q;
      discard_d  = discard_q;
`endif
      case (state_q)
         IDLE: begin
            if (en) state_d = ARM;
            else    state_d = IDLE;
         end
         ARM: begin
            gate_cnt_d = {GW{1'b0}};
            edge_cnt_d = {CNT_W{1'b0}};
            sat_d      = 1'b0;
            if (en) state_d = GATE;
            else    state_d = IDLE;
         end
         GATE: begin
            if (last_s) begin
               // Counters restart here so the next cycle already belongs to the new window.
               gate_cnt_d = {GW{1'b0}};
               edge_cnt_d = {CNT_W{1'b0}};
               sat_d      = 1'b0;
`ifdef FREQ_METER_AUTORANGE_EN
               if (discard_q) begin
                  discard_d = 1'b0;
               end else begin
                  valid_d = 1'b1;
                  if (range_q) begin
                     freq_d = mul_s.val[CNT_W-1:0];
                     ovf_d  = win_ovf_s | scaled_ovf_s;
                     if (raw_s < LO_TH) begin
                        range_d   = 1'b0;
                        discard_d = 1'b1;
                     end else begin
                        range_d   = 1'b1;
                        discard_d = 1'b0;
                     end
                  end else begin
                     freq_d = raw_s;
                     ovf_d  = win_ovf_s;
                     if ((raw_s >= HI_TH) || win_ovf_s) begin
                        range_d   = 1'b1;
                        discard_d = 1'b1;
                     end else begin
                        range_d   = 1'b0;
                        discard_d = 1'b0;
                     end
                  end
               end
`else
               valid_d = 1'b1;
               freq_d  = raw_s;
               ovf_d   = win_ovf_s;
`endif
               if (en) state_d = GATE;
               else    state_d = IDLE;
            end else if (!en) begin
               state_d = IDLE;
            end else begin
               gate_cnt_d = gate_cnt_q + GW'(1'b1);
               edge_cnt_d = raw_s;
               sat_d      = win_ovf_s;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State, counter and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         gate_cnt_q <= {GW{1'b0}};
         edge_cnt_q <= {CNT_W{1'b0}};
         sat_q      <= 1'b0;
         freq_q     <= {CNT_W{1'b0}};
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
`ifdef FREQ_METER_AUTORANGE_EN
         range_q    <= 1'b0;
         discard_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         sat_q      <= sat_d;
         freq_q     <= freq_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
`ifdef FREQ_METER_AUTORANGE_EN
         range_q    <= range_d;
         discard_q  <= discard_d;
`endif
      end
   end

   assign freq       = freq_q;
   assign freq_valid = valid_q;
   assign overflow   = ovf_q;
   assign busy       = busy_q;
`ifdef FREQ_METER_AUTORANGE_EN
   assign range_sel  = range_q;
`else
   assign range_sel  = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed self-checking bench for freq_meter (GATE_CYCLES=100).
// Autorange checks are compiled in when FREQ_METER_AUTORANGE_EN is defined.
module tb_freq_meter;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_a, en_b;
   logic       sig_a, sig_b, sig_div;
   logic [7:0] freq_a;
   logic       valid_a, ovf_a, busy_a, range_a;
   logic [3:0] freq_b;
   logic       valid_b, ovf_b, busy_b, range_b;

   int errors = 0;
   int checks = 0;
   int per    = 10;
   int ph     = 0;
   int dcnt   = 0;
   bit lvl    = 1'b0;
   bit tog_b  = 1'b0;

   always #5 clk = ~clk;

   freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .SYNC_STAGES(2),
                .HI_TH(8'd200), .LO_TH(8'd8)) u_a (
      .clk(clk), .rst(rst), .en(en_a), .sig_in(sig_a), .freq(freq_a),
      .freq_valid(valid_a), .overflow(ovf_a), .busy(busy_a), .range_sel(range_a));

   freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2),
                .HI_TH(4'd15), .LO_TH(4'd1)) u_b (
      .clk(clk), .rst(rst), .en(en_b), .sig_in(sig_b), .freq(freq_b),
      .freq_valid(valid_b), .overflow(ovf_b), .busy(busy_b), .range_sel(range_b));

`ifdef FREQ_METER_AUTORANGE_EN
   logic       en_c, sig_c;
   logic [7:0] freq_c;
   logic       valid_c, ovf_c, busy_c, range_c;
   assign sig_c = range_c ? sig_div : sig_a;

   freq_meter #(.GATE_CYCLES(200), .CNT_W(8), .SYNC_STAGES(2),
                .HI_TH(8'd90), .LO_TH(8'd8)) u_c (
      .clk(clk), .rst(rst), .en(en_c), .sig_in(sig_c), .freq(freq_c),
      .freq_valid(valid_c), .overflow(ovf_c), .busy(busy_c), .range_sel(range_c));
`endif

   // Stimulus generator: periodic sig_a (or level lvl), /10 prescaler model, toggling sig_b.
   initial begin
      bit nxt;
      sig_a   = 1'b0;
      sig_b   = 1'b0;
      sig_div = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (per != 0) begin
            ph  = (ph + 1 >= per) ? 0 : ph + 1;
            nxt = (ph < per / 2);
         end else begin
            nxt = lvl;
         end
         if (nxt && !sig_a) begin
            dcnt    = (dcnt == 9) ? 0 : dcnt + 1;
            sig_div = (dcnt < 5);
         end
         sig_a = nxt;
         if (tog_b) sig_b = ~sig_b;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag, input int sel, input int budget, output int n);
      logic v;
      n = 0;
      v = 1'b0;
      while (!v && n < budget) begin
         @(negedge clk);
         n++;
         if (sel == 0)      v = valid_a;
         else if (sel == 1) v = valid_b;
`ifdef FREQ_METER_AUTORANGE_EN
         else               v = valid_c;
`else
         else               v = valid_b;
`endif
      end
      check(tag, {31'd0, v}, 32'd1);
   endtask

   initial begin
      int   n;
      int   vcount;
      logic found;
      rst  = 1'b1;
      en_a = 1'b0;
      en_b = 1'b0;
`ifdef FREQ_METER_AUTORANGE_EN
      en_c = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_freq",  32'(freq_a),  32'd0);
      check("rst_valid", 32'(valid_a), 32'd0);
      check("rst_ovf",   32'(ovf_a),   32'd0);
      check("rst_busy",  32'(busy_a),  32'd0);
      check("rst_range", 32'(range_a), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Period-10 input: 10 edges per window, first result 1 + 100 cycles after ARM.
      en_a = 1'b1;
      wait_valid("t1_seen", 0, 200, n);
      check("t1_latency", 32'(n),      32'd102);
      check("t1_freq",    32'(freq_a), 32'd10);
      check("t1_ovf",     32'(ovf_a),  32'd0);
      check("t1_busy",    32'(busy_a), 32'd1);
      @(negedge clk);
      check("t1_pulse",   32'(valid_a), 32'd0);
      wait_valid("t1_seen2", 0, 200, n);
      check("t1_period",  32'(n),       32'd99);
      check("t1_freq2",   32'(freq_a),  32'd10);
      check("t1_busy2",   32'(busy_a),  32'd1);
      check("t1_range",   32'(range_a), 32'd0);

      // Period-2 input into a 4-bit counter saturates every window.
      tog_b = 1'b1;
      en_b  = 1'b1;
      wait_valid("t2_seen", 1, 300, n);
      check("t2_freq", 32'(freq_b), 32'd15);
      check("t2_ovf",  32'(ovf_b),  32'd1);
      wait_valid("t2_seen2", 1, 300, n);
      check("t2_freq2", 32'(freq_b), 32'd15);
      check("t2_ovf2",  32'(ovf_b),  32'd1);
      en_b = 1'b0;

      // Abort mid-window: no result, previous freq held, idle one cycle later.
      wait_valid("t3_sync", 0, 200, n);
      repeat (50) @(negedge clk);
      en_a = 1'b0;
      @(negedge clk);
      check("t3_busy", 32'(busy_a), 32'd0);
      vcount = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (valid_a) vcount++;
      end
      check("t3_no_valid", 32'(vcount), 32'd0);
      check("t3_freq_hold", 32'(freq_a), 32'd10);

      // Reset mid-window clears everything at once; re-arm measures correctly.
      en_a = 1'b1;
      wait_valid("t4_seen", 0, 200, n);
      check("t4_latency", 32'(n), 32'd102);
      repeat (70) @(negedge clk);
      rst = 1'b1;
      #1;
      check("t4_rst_freq",  32'(freq_a),  32'd0);
      check("t4_rst_busy",  32'(busy_a),  32'd0);
      check("t4_rst_valid", 32'(valid_a), 32'd0);
      check("t4_rst_ovf",   32'(ovf_a),   32'd0);
      en_a = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      en_a = 1'b1;
      wait_valid("t4_seen2", 0, 200, n);
      check("t4_relatency", 32'(n),      32'd102);
      check("t4_refreq",    32'(freq_a), 32'd10);

      // Constant input gives zero; single pulses near the window end.
      per = 0;
      lvl = 1'b1;
      wait_valid("t5_skip1", 0, 200, n);
      wait_valid("t5_seen1", 0, 200, n);
      check("t5_hi_freq", 32'(freq_a), 32'd0);
      check("t5_hi_ovf",  32'(ovf_a),  32'd0);
      lvl = 1'b0;
      wait_valid("t5_skip0", 0, 200, n);
      wait_valid("t5_seen0", 0, 200, n);
      check("t5_lo_freq", 32'(freq_a), 32'd0);
      check("t5_lo_ovf",  32'(ovf_a),  32'd0);
      repeat (96) @(negedge clk);
      lvl = 1'b1;
      @(negedge clk);
      lvl = 1'b0;
      wait_valid("t5_seen97", 0, 200, n);
      check("t5_term_edge", 32'(freq_a), 32'd1);
      repeat (98) @(negedge clk);
      lvl = 1'b1;
      @(negedge clk);
      lvl = 1'b0;
      wait_valid("t5_seen99", 0, 200, n);
      check("t5_late_pulse_cur", 32'(freq_a), 32'd0);
      wait_valid("t5_seen_nxt", 0, 200, n);
      check("t5_late_pulse_nxt", 32'(freq_a), 32'd1);
      en_a = 1'b0;

`ifdef FREQ_METER_AUTORANGE_EN
      // Autorange: raw 100 >= 90 switches to /10, next window silent, then 10*10.
      per = 2;
      repeat (20) @(negedge clk);
      en_c = 1'b1;
      wait_valid("ar_seen1", 2, 300, n);
      check("ar_freq_raw", 32'(freq_c),  32'd100);
      check("ar_range_up", 32'(range_c), 32'd1);
      wait_valid("ar_seen2", 2, 500, n);
      check("ar_discard_gap", 32'(n),      32'd400);
      check("ar_freq_scaled", 32'(freq_c), 32'd100);
      check("ar_ovf",         32'(ovf_c),  32'd0);
      per   = 20;
      found = 1'b0;
      for (int k = 0; k < 4 && !found; k++) begin
         wait_valid("ar_seen_dn", 2, 500, n);
         if (range_c == 1'b0) found = 1'b1;
      end
      check("ar_range_down", 32'(found), 32'd1);
      wait_valid("ar_seen3", 2, 500, n);
      check("ar_discard_gap2", 32'(n),       32'd400);
      check("ar_freq_low",     32'(freq_c),  32'd10);
      check("ar_range_low",    32'(range_c), 32'd0);
      en_c = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
